// File: rtl/llr_pkg.sv
// LLR quantizer shared defaults, FSM encoding and arithmetic helpers.
// Optional saturation counter is built when LLR_SATCNT_EN is defined.
package llr_pkg;

  localparam int LLR_IW = 35;
  localparam int LLR_LW = 6;
  localparam int XW = 64;

  typedef logic signed [XW-1:0] wide_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEND_I = 2'd1;
  localparam logic [1:0] ST_SEND_Q = 2'd2;

  // Round half up, then arithmetic right shift; wide enough never to wrap.
  function automatic wide_t rnd_shift(
    input wide_t      x,
    input logic [4:0] s
  );
    wide_t bias;
    bias = '0;
    if (s != 5'd0) bias[s - 5'd1] = 1'b1;
    return (x + bias) >>> s;
  endfunction

  // Symmetric clip to +/-(2^(lw-1)-1).
  function automatic wide_t sat_sym(
    input wide_t v,
    input int    lw
  );
    wide_t lim;
    lim = (wide_t'(1) <<< (lw - 1)) - wide_t'(1);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/llr_fifo.sv
// Show-ahead synchronous FIFO holding quantized (q, i) pairs.
// Optional saturation counter is built when LLR_SATCNT_EN is defined.
module llr_fifo #(
  parameter int DW    = 12,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  // A full FIFO still takes a write when the same cycle frees a slot.
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rptr];

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wptr] <= wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + AW'(1);
      if (rd_en) rptr <= rptr + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/llr_quantizer.sv
// Rounds, scales and saturates product pairs to LLRs and serialises I/Q.
// Optional saturation counter is built when LLR_SATCNT_EN is defined.
module llr_quantizer
  import llr_pkg::*;
#(
  parameter int IW         = LLR_IW,
  parameter int LW         = LLR_LW,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_MARGIN  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic signed [IW-1:0] i_pre,
  input  logic signed [IW-1:0] i_pim,
  input  logic                 i_valid,
  input  logic [4:0]           i_shift,
  output logic                 o_afull,
  output logic signed [LW-1:0] o_llr,
  output logic                 o_llr_valid,
  output logic                 o_llr_last,
  input  logic                 i_llr_ready,
  output logic                 o_ovf
`ifdef LLR_SATCNT_EN
  ,
  output logic [15:0]          o_sat_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] AF_TH =
    CW'(FIFO_DEPTH - AF_MARGIN);

  logic               v1;
  logic signed [IW:0] re1;
  logic signed [IW:0] im1;

  logic                 v2;
  logic signed [LW-1:0] qi2;
  logic signed [LW-1:0] qq2;
  logic signed [LW-1:0] qi_n;
  logic signed [LW-1:0] qq_n;

  logic [2*LW-1:0] rdata;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic            pop;

  logic [1:0]      state;
  logic [LW-1:0]   q_hold;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1  <= 1'b0;
      re1 <= '0;
      im1 <= '0;
    end else begin
      v1 <= i_valid;
      if (i_valid) begin
        re1 <= (IW+1)'(rnd_shift(wide_t'(i_pre), i_shift));
        im1 <= (IW+1)'(rnd_shift(wide_t'(i_pim), i_shift));
      end
    end
  end

  assign qi_n = LW'(sat_sym(wide_t'(re1), LW));
  assign qq_n = LW'(sat_sym(wide_t'(im1), LW));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v2  <= 1'b0;
      qi2 <= '0;
      qq2 <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        qi2 <= qi_n;
        qq2 <= qq_n;
      end
    end
  end

  llr_fifo #(
    .DW    (2 * LW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (v2),
    .wdata   ({qq2, qi2}),
    .pop     (pop),
    .rdata   (rdata),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_afull <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      o_afull <= (count >= AF_TH);
      if (v2 && full && !pop) o_ovf <= 1'b1;
    end
  end

  always_comb begin
    pop = 1'b0;
    unique case (state)
      ST_IDLE:   pop = !empty;
      ST_SEND_Q: pop = i_llr_ready && !empty;
      default:   pop = 1'b0;
    endcase
  end

  // Output is registered; Q waits in q_hold while I is on the bus.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      o_llr       <= '0;
      o_llr_valid <= 1'b0;
      o_llr_last  <= 1'b0;
      q_hold      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!empty) begin
            o_llr       <= rdata[LW-1:0];
            q_hold      <= rdata[2*LW-1:LW];
            o_llr_valid <= 1'b1;
            o_llr_last  <= 1'b0;
            state       <= ST_SEND_I;
          end
        end
        ST_SEND_I: begin
          if (i_llr_ready) begin
            o_llr      <= q_hold;
            o_llr_last <= 1'b1;
            state      <= ST_SEND_Q;
          end
        end
        ST_SEND_Q: begin
          if (i_llr_ready) begin
            if (!empty) begin
              o_llr      <= rdata[LW-1:0];
              q_hold     <= rdata[2*LW-1:LW];
              o_llr_last <= 1'b0;
              state      <= ST_SEND_I;
            end else begin
              o_llr_valid <= 1'b0;
              o_llr_last  <= 1'b0;
              state       <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LLR_SATCNT_EN
  logic        sat_i;
  logic        sat_q;
  logic [16:0] sat_sum;

  assign sat_i = (wide_t'(qi_n) != wide_t'(re1));
  assign sat_q = (wide_t'(qq_n) != wide_t'(im1));
  assign sat_sum = {1'b0, o_sat_cnt}
                 + 17'(sat_i) + 17'(sat_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sat_cnt <= '0;
    end else if (v1) begin
      o_sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end
`endif

endmodule
